fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the 16-bit word-addressed program memory.
- Drives the memory read strobe and address, captures the returned instruction word into an instruction register (IR), and hands it to decode with a valid/ready handshake.
- Supports PC redirect (branch/jump) from execute, with a configurable memory read latency.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_wait_counter.sv | 24 ++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, reusable by decode.
// The FETCH_HALT_EN build makes HALT a reachable state.
package fetch_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 16'h0000;
  localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    FULL = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Program-memory and decode-side signals of the fetch stage.
// The master modport is the fetch unit itself.
interface fetch_if;
  import fetch_pkg::*;

  logic              mem_read;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              halted;

  modport master (
    output mem_read, mem_addr, ir, ir_pc, ir_valid, halted,
    input  mem_data, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_read, mem_addr, ir, ir_pc, ir_valid, halted,
    output mem_data, ir_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_wait_counter.sv
// 4-bit memory latency counter; done marks the cycle whose edge samples mem_data.
module fetch_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [3:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign done = (count == 4'(MEM_LATENCY - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register and fetch FSM.
// Define FETCH_HALT_EN to stop fetching after HALT_WORD is accepted.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                WORD_W      = fetch_pkg::WORD_W,
  parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int                MEM_LATENCY = 1,
  parameter logic [WORD_W-1:0] HALT_WORD   = HALT_WORD_DEFAULT
) (
  input logic  clock,
  input logic  reset,
  fetch_if.master bus
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_ENABLED = 1'b1;
`else
  localparam bit HALT_ENABLED = 1'b0;
`endif

  fetch_state_t      state, state_next;
  logic [WORD_W-1:0] pc, ir, ir_pc;
  logic              ir_valid;
  logic              mem_read, count_en, wait_done, capture, accept;

  fetch_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
    .clock  (clock),
    .reset  (reset),
    .clear  (bus.redirect || capture),
    .enable (count_en),
    .done   (wait_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= REQ;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.redirect) begin
      state_next = REQ;
    end else begin
      case (state)
        REQ:     if (wait_done) state_next = FULL;
        FULL:    if (accept) state_next = (HALT_ENABLED && ir == HALT_WORD) ? HALT : REQ;
        HALT:    state_next = HALT;
        default: state_next = REQ;
      endcase
    end
  end

  always_comb begin
    mem_read = (state == REQ) && !reset;
    count_en = (state == REQ);
    capture  = (state == REQ) && wait_done && !bus.redirect;
    accept   = ir_valid && bus.ir_ready;
  end

  // Redirect discards any held or in-flight word; capture cannot coincide with a held one.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (bus.redirect) begin
      pc       <= bus.redirect_pc;
      ir_valid <= 1'b0;
    end else if (capture) begin
      ir       <= bus.mem_data;
      ir_pc    <= pc;
      pc       <= pc + WORD_W'(1);
      ir_valid <= 1'b1;
    end else if (accept) begin
      ir_valid <= 1'b0;
    end
  end

  assign bus.mem_read = mem_read;
  assign bus.mem_addr = pc;
  assign bus.ir       = ir;
  assign bus.ir_pc    = ir_pc;
  assign bus.ir_valid = ir_valid;

`ifdef FETCH_HALT_EN
  assign bus.halted = (state == HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: one instance at latency 1, one at latency 3.
// Halt checks follow FETCH_HALT_EN.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_if bus1 ();
  fetch_if bus3 ();

  fetch_unit #(.MEM_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1.master));
  fetch_unit #(.MEM_LATENCY(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3.master));

  logic [15:0] mem [256];
  assign bus1.mem_data = mem[bus1.mem_addr[7:0]];
  assign bus3.mem_data = mem[bus3.mem_addr[7:0]];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q1[$];
  logic [31:0] q3[$];
  logic [31:0] e1, e3;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic rdy1, input logic rd1, input logic [15:0] rpc1,
                               input logic rdy3, input logic rd3, input logic [15:0] rpc3);
    reset            = rst;
    bus1.ir_ready    = rdy1;
    bus1.redirect    = rd1;
    bus1.redirect_pc = rpc1;
    bus3.ir_ready    = rdy3;
    bus3.redirect    = rd3;
    bus3.redirect_pc = rpc3;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Every accepted instruction must match the head of its scoreboard queue.
  always @(negedge clock) begin
    if (!reset && bus1.ir_valid && bus1.ir_ready && !bus1.redirect) begin
      checkOutput("sb1_avail", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        checkOutput("sb1_ir", 32'(bus1.ir), 32'(e1[15:0]));
        checkOutput("sb1_pc", 32'(bus1.ir_pc), 32'(e1[31:16]));
      end
    end
    if (!reset && bus3.ir_valid && bus3.ir_ready && !bus3.redirect) begin
      checkOutput("sb3_avail", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e3 = q3.pop_front();
        checkOutput("sb3_ir", 32'(bus3.ir), 32'(e3[15:0]));
        checkOutput("sb3_pc", 32'(bus3.ir_pc), 32'(e3[31:16]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'h5A, 8'(i)};
    mem[0]     = 16'h1111;
    mem[1]     = 16'h2222;
    mem[2]     = 16'h3333;
    mem[8'h20] = 16'hFFFF;

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    repeat (3) stepCycle();
    checkOutput("rst_rd1", 32'(bus1.mem_read), 32'd0);
    checkOutput("rst_rd3", 32'(bus3.mem_read), 32'd0);
    checkOutput("rst_val1", 32'(bus1.ir_valid), 32'd0);
    checkOutput("rst_ir1", 32'(bus1.ir), 32'd0);
    checkOutput("rst_irpc1", 32'(bus1.ir_pc), 32'd0);
    checkOutput("rst_addr1", 32'(bus1.mem_addr), 32'd0);
    checkOutput("rst_halt1", 32'(bus1.halted), 32'd0);
    checkOutput("rst_val3", 32'(bus3.ir_valid), 32'd0);

    // Release reset with decode stalled: first word is held under backpressure.
    q1.push_back({16'h0000, 16'h1111});
    q1.push_back({16'h0001, 16'h2222});
    q1.push_back({16'h0002, 16'h3333});
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    #1;
    checkOutput("rel_rd1", 32'(bus1.mem_read), 32'd1);
    checkOutput("rel_addr1", 32'(bus1.mem_addr), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      stepCycle();
      checkOutput("bp_val", 32'(bus1.ir_valid), 32'd1);
      checkOutput("bp_ir", 32'(bus1.ir), 32'h1111);
      checkOutput("bp_rd", 32'(bus1.mem_read), 32'd0);
      checkOutput("bp_pc", 32'(bus1.mem_addr), 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    for (int i = 6; i <= 11; i++) begin
      stepCycle();
      checkOutput("run_val", 32'(bus1.ir_valid), 32'(i % 2));
      checkOutput("run_rd", 32'(bus1.mem_read), 32'((i + 1) % 2));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("run_drain", 32'(q1.size()), 32'd0);

    // Latency 3: redirect away from pc=5 while its read is one cycle in.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0005);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0005);
    stepCycle();
    checkOutput("l3_addr5", 32'(bus3.mem_addr), 32'h5);
    checkOutput("l3_rd5", 32'(bus3.mem_read), 32'd1);
    checkOutput("l3_val5", 32'(bus3.ir_valid), 32'd0);
    q3.delete();
    q3.push_back({16'h0040, 16'h5A40});
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0040);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("l3_wait_rd", 32'(bus3.mem_read), 32'd1);
      checkOutput("l3_wait_addr", 32'(bus3.mem_addr), 32'h40);
      checkOutput("l3_wait_val", 32'(bus3.ir_valid), 32'd0);
      stepCycle();
    end
    checkOutput("l3_cap_val", 32'(bus3.ir_valid), 32'd1);
    checkOutput("l3_cap_pc", 32'(bus3.ir_pc), 32'h40);
    checkOutput("l3_cap_ir", 32'(bus3.ir), 32'h5A40);
    checkOutput("l3_cap_rd", 32'(bus3.mem_read), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("l3_acc_val", 32'(bus3.ir_valid), 32'd0);
    checkOutput("l3_drain", 32'(q3.size()), 32'd0);

    // PC wraps from FFFF to 0000.
    q1.delete();
    q1.push_back({16'hFFFF, 16'h5AFF});
    q1.push_back({16'h0000, 16'h1111});
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("wr_val0", 32'(bus1.ir_valid), 32'd0);
    checkOutput("wr_addr", 32'(bus1.mem_addr), 32'hFFFF);
    stepCycle();
    checkOutput("wr_irpc", 32'(bus1.ir_pc), 32'hFFFF);
    checkOutput("wr_next", 32'(bus1.mem_addr), 32'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    stepCycle();
    checkOutput("wr_rd", 32'(bus1.mem_read), 32'd1);
    stepCycle();
    checkOutput("wr_irpc0", 32'(bus1.ir_pc), 32'h0000);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("wr_drain", 32'(q1.size()), 32'd0);
    stepCycle();
    checkOutput("wr_held", 32'(bus1.ir_valid), 32'd1);

    // Redirect together with ready, landing on the halt word.
    q1.delete();
    q1.push_back({16'h0020, 16'hFFFF});
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("rr_val", 32'(bus1.ir_valid), 32'd0);
    checkOutput("rr_addr", 32'(bus1.mem_addr), 32'h20);
    stepCycle();
    checkOutput("hw_val", 32'(bus1.ir_valid), 32'd1);
    checkOutput("hw_ir", 32'(bus1.ir), 32'hFFFF);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
`ifdef FETCH_HALT_EN
    for (int k = 0; k < 10; k++) begin
      checkOutput("h_halted", 32'(bus1.halted), 32'd1);
      checkOutput("h_rd", 32'(bus1.mem_read), 32'd0);
      checkOutput("h_pc", 32'(bus1.mem_addr), 32'h21);
      stepCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("h_clear", 32'(bus1.halted), 32'd0);
    checkOutput("h_resume_rd", 32'(bus1.mem_read), 32'd1);
    checkOutput("h_resume_addr", 32'(bus1.mem_addr), 32'h0);
    stepCycle();
    checkOutput("h_resume_ir", 32'(bus1.ir), 32'h1111);
`else
    checkOutput("nh_halted", 32'(bus1.halted), 32'd0);
    checkOutput("nh_rd", 32'(bus1.mem_read), 32'd1);
    checkOutput("nh_addr", 32'(bus1.mem_addr), 32'h21);
    stepCycle();
    checkOutput("nh_irpc", 32'(bus1.ir_pc), 32'h21);
    checkOutput("nh_halted2", 32'(bus1.halted), 32'd0);
`endif
    checkOutput("hw_drain", 32'(q1.size()), 32'd0);
    checkOutput("mf_full", 32'(bus1.ir_valid), 32'd1);

    // Reset while holding a word behaves like power-up.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    stepCycle();
    checkOutput("mr_val1", 32'(bus1.ir_valid), 32'd0);
    checkOutput("mr_pc1", 32'(bus1.mem_addr), 32'h0);
    checkOutput("mr_rd1", 32'(bus1.mem_read), 32'd0);
    checkOutput("mr_halt1", 32'(bus1.halted), 32'd0);
    checkOutput("mr_val3", 32'(bus3.ir_valid), 32'd0);
    checkOutput("mr_pc3", 32'(bus3.mem_addr), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    #1;
    checkOutput("mr_rel_rd", 32'(bus1.mem_read), 32'd1);
    stepCycle();
    checkOutput("mr_cap_val", 32'(bus1.ir_valid), 32'd1);
    checkOutput("mr_cap_ir", 32'(bus1.ir), 32'h1111);
    checkOutput("mr_cap_pc", 32'(bus1.ir_pc), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
